// File: rtl/core_pipe_pkg.sv
// Shared definitions for the 5-stage core's inter-stage buffers: stall vector
// width, stage indices and the packed payload layouts that size DATA_W.
package core_pipe_pkg;

  localparam int CORE_STALL_W = 8;

  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [14:0] excepttype;
  } id_ex_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
    logic [14:0] excepttype;
    logic [31:0] pc;
  } ex_mem_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping; clr beats inc.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage register between stage STAGE and STAGE+1 with stall/flush handling,
// optional one-entry skid buffer for a late stall, sticky overflow and perf counters.
module pipe_stage_buf
  import core_pipe_pkg::*;
#(
  parameter int DATA_W  = ID_EX_W,
  parameter int STALL_W = CORE_STALL_W,
  parameter int STAGE   = STG_ID,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               skid_full,
  output logic               overflow,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
    $error("pipe_stage_buf: STAGE must lie in 0..STALL_W-2");
  end

  logic hold_up;
  logic hold_dn;
  logic unused_stall;

  assign hold_up      = stall[STAGE];
  assign hold_dn      = stall[STAGE+1];
  assign unused_stall = ^stall;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              skid_vld;
  logic [DATA_W-1:0] skid_data;
  logic              ovf_q;

  // Skid entry: absorbs one payload when the downstream freeze is seen a cycle late
  if (SKID != 0) begin : g_skid
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        skid_vld  <= 1'b0;
        skid_data <= '0;
      end else if (flush) begin
        skid_vld  <= 1'b0;
        skid_data <= '0;
      end else if (!hold_up && in_valid && (hold_dn ? !skid_vld : skid_vld)) begin
        skid_vld  <= 1'b1;
        skid_data <= in_data;
      end else if (!hold_dn) begin
        skid_vld  <= 1'b0;
        skid_data <= '0;
      end
    end
  end else begin : g_no_skid
    assign skid_vld  = 1'b0;
    assign skid_data = '0;
  end

  // Output register stage p1: skid contents drain ahead of new input to keep order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (hold_dn) begin
      if (!hold_up && in_valid && ((SKID == 0) || skid_vld)) begin
        ovf_q <= 1'b1;
      end
    end else if (skid_vld) begin
      vld_p1  <= 1'b1;
      data_p1 <= skid_data;
    end else if (!hold_up) begin
      vld_p1  <= in_valid;
      data_p1 <= in_valid ? in_data : '0;
    end else begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end
  end

  logic bubble_inc;
  assign bubble_inc = !flush && !hold_dn && !skid_vld && hold_up;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bubble_inc),
    .clr (cnt_clr),
    .cnt (bubble_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .clr (cnt_clr),
    .cnt (flush_cnt)
  );

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign skid_full = skid_vld;
  assign overflow  = ovf_q;

endmodule
